instr_queue: RTL
================

# instr_queue

Instruction buffer between the fetch stage and the decode stage of the RISC-V core. It captures each fetched {PC, instruction} pair, holds up to DEPTH entries, and presents them to decode in program order over a valid/ready handshake. A flush input empties it when a taken branch or jump redirects fetch. This decouples fetch from decode stalls without changing the instruction-memory timing.

## Interface

- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 10: PC width; matches the instruction-memory address width.
- DATA_W, 32: instruction width.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue accepts an entry this cycle.
- in_pc  input  ADDR_W  PC of the fetched instruction.
- in_instr  input  DATA_W  fetched instruction.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  ADDR_W  PC of the head entry.
- out_instr  output  DATA_W  head instruction; NOP 0x00000013 when out_valid=0.
- flush  input  1  discard all entries, including any input in the same cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage is a circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap) and a count register.
- Push: in_valid && in_ready. Writes {in_pc, in_instr} at wr_ptr, then wr_ptr+1.
- Pop: out_valid && out_ready. rd_ptr+1.
- in_ready = (count != DEPTH). It is combinational from registered count only and never depends on out_ready, so there is no push while full even if a pop occurs.
- out_valid = (count != 0). out_pc and out_instr read mem[rd_ptr] combinationally.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Flush has priority over push and pop. Pointers and count go to 0 at the next edge, and the entry presented in the flush cycle is dropped. Array contents are not cleared.
- Reset: same effect as flush, plus all array entries are written to PC 0 and instruction 0x00000013.
- When out_valid=0, out_instr is forced to 0x00000013 and out_pc to 0.
- Pointer wrap needs no special handling: DEPTH is a power of two, so modular arithmetic is implicit.

## Timing

- Latency is one cycle: an entry pushed at edge N is visible at the output after edge N (out_valid=1 in cycle N+1). The exception is the bypass mode in Configuration.
- Throughput is one push and one pop per cycle sustained.
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_instr=0x00000013, count=0.
- Reset mid-stream discards all entries at the same edge. in_ready=1 in the following cycle.
- Flush during reset: reset dominates, with an identical result.
- in_ready and out_valid are registered-state functions, so the handshakes have no combinational loop through the block.

## Configuration

- INSTR_QUEUE_BYPASS_EN defined:
  - When count==0, in_valid=1 and flush=0, the input passes straight through combinationally.
  - out_valid=1, out_pc=in_pc, out_instr=in_instr in the same cycle.
  - If out_ready=1 the entry is consumed and not stored; count stays 0.
  - If out_ready=0 it is stored normally.
- INSTR_QUEUE_BYPASS_EN undefined: the output comes only from storage, with the strict one-cycle latency above.

## Structure

- Shared package (core package) holds:
  - the NOP encoding constant 0x00000013;
  - the ADDR_W/DATA_W defaults (10/32);
  - a packed fetch-entry typedef {pc, instr} reused by fetch and decode.
- One sub-module is natural: instr_queue_mem, the DEPTH×(ADDR_W+DATA_W) register array with a synchronous write port, an asynchronous read port and a synchronous reset-to-NOP. Pointer, count and handshake logic stay in instr_queue.

## Test plan

- Reset then idle: out_valid=0, out_instr=0x00000013, in_ready=1, count=0 for 5 cycles.
- Push PCs 0x000, 0x004, 0x008, 0x00C with out_ready=0: count reaches 4, in_ready=0. A fifth push (PC 0x010) is refused, and the output stays PC 0x000.
- Full queue, out_ready=1 for 4 cycles: outputs are PCs 0x000, 0x004, 0x008, 0x00C in order. count ends at 0 and in_ready is 1 from the first pop onward.
- Continuous push and pop over 10 entries, PC 0x000 to 0x024: pointers wrap twice, order is preserved, and count stays at 1 (0 with INSTR_QUEUE_BYPASS_EN).
- count=3, flush=1 with in_valid=1 and PC 0x100: next cycle count=0, out_valid=0, and PC 0x100 never appears.
- With INSTR_QUEUE_BYPASS_EN, empty queue, in_valid=1, PC 0x040, instruction 0x00500093, out_ready=1: same-cycle out_valid=1, out_pc=0x040, count stays 0.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode definitions: NOP encoding, default widths and the fetch-entry type.
package instr_queue_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue bus; master drives fetch side and consumer ready, slave is the queue.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                         in_valid;
    logic                         in_ready;
    logic [ADDR_W-1:0]            in_pc;
    logic [DATA_W-1:0]            in_instr;
    logic                         out_valid;
    logic                         out_ready;
    logic [ADDR_W-1:0]            out_pc;
    logic [DATA_W-1:0]            out_instr;
    logic                         flush;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/instr_queue_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, synchronous reset to RESET_VAL.
module instr_queue_mem
    import instr_queue_pkg::*;
#(
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      WIDTH     = ADDR_W_DEF + DATA_W_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        // NOTE: copy the whole array first so every element has a value on every path and no latch is inferred.
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: state uses <= so all flops update together at the edge; always_comb uses = to compute next values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: entries are reset explicitly so a freshly reset core reads NOPs, not X, from stale slots.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer with valid/ready handshakes and flush.
// Define INSTR_QUEUE_BYPASS_EN for same-cycle pass-through when the queue is empty.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic          clk,
    input logic          reset,
    instr_queue_if.slave q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stored_valid, bypass, out_valid, push, pop_stored, write;
    entry_t           wr_entry, rd_entry;

    assign stored_valid = (count_q != '0);
    assign q.in_ready   = (count_q != CNT_W'(DEPTH));
    assign q.count      = count_q;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass = !stored_valid && q.in_valid && !q.flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid  = stored_valid || bypass;
    assign push       = q.in_valid && q.in_ready;
    assign pop_stored = stored_valid && q.out_ready;
    // A bypassed entry taken by decode in the same cycle never enters storage.
    assign write      = push && !q.flush && !(bypass && q.out_ready);
    assign wr_entry   = '{pc: q.in_pc, instr: q.in_instr};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write)      wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_stored) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(write) - CNT_W'(pop_stored);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        q.out_valid = out_valid;
        q.out_pc    = '0;
        q.out_instr = NOP;
        if (stored_valid) begin
            q.out_pc    = rd_entry.pc;
            q.out_instr = rd_entry.instr;
        end else if (bypass) begin
            q.out_pc    = q.in_pc;
            q.out_instr = q.in_instr;
        end
    end

    instr_queue_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (ADDR_W + DATA_W),
        .RESET_VAL ({{ADDR_W{1'b0}}, NOP})
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (write),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

endmodule
